// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, RAM-state and arbiter-state types.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
  typedef enum logic [1:0] {IDLE = 2'd0, DGRANT = 2'd1, IGRANT = 2'd2} arb_state_t;
endpackage

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one RAM port between instruction fetch and data access,
// data first, with a streak limit so a pending fetch is never starved.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int MAX_DSTREAK = 4,
  parameter int CNT_W = 3
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      ram_err
);
  localparam logic [CNT_W-1:0] MAXS = CNT_W'(MAX_DSTREAK);
  arb_state_t r_state, w_next;
  logic [CNT_W-1:0] r_streak;
  logic w_dreq, w_acc, w_d, w_i;
  assign w_dreq = dREN | dWEN;
  assign w_acc = ramstate == ACCESS;
  assign w_d = r_state == DGRANT;
  assign w_i = r_state == IGRANT;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) r_state <= IDLE;
    else r_state <= w_next;
  // completions only: aborts leave the streak untouched
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) r_streak <= '0;
    else if (w_d && w_dreq && w_acc) r_streak <= !iREN ? '0 : r_streak == MAXS ? r_streak : r_streak + 1'b1;
    else if (w_i && iREN && w_acc) r_streak <= '0;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (w_dreq && !(iREN && r_streak == MAXS)) ? DGRANT : iREN ? IGRANT : IDLE;
      DGRANT:  w_next = (!w_dreq || w_acc) ? IDLE : DGRANT;
      IGRANT:  w_next = (!iREN || w_acc) ? IDLE : IGRANT;
      default: w_next = IDLE;
    endcase
    ramREN   = w_d ? dREN & ~dWEN : w_i;
    ramWEN   = w_d & dWEN;
    ramaddr  = w_d ? daddr : w_i ? iaddr : '0;
    ramstore = w_d ? dstore : '0;
    dwait    = ~(w_d & w_acc);
    iwait    = ~(w_i & w_acc);
    ram_err  = (w_d | w_i) & (ramstate == ERROR);
    iload    = ramload;
    dload    = ramload;
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed stimulus with a completion scoreboard for ram_arbiter.
module tb_ram_arbiter;
  import cpu_types_pkg::*;
  localparam word_t K = 32'h5A5A_5A5A;
  typedef struct {logic side; word_t addr; logic wr; word_t data;} exp_t;
  exp_t sb[$];
  logic CLK = 0, nRST = 0, iREN = 0, dREN = 0, dWEN = 0;
  word_t iaddr = 0, daddr = 0, dstore = 0, iload, dload, ramaddr, ramstore, ramload;
  logic iwait, dwait, ramREN, ramWEN, ram_err;
  ramstate_t ramstate;
  int passed = 0, total = 0, cnt = 0, lat = 1, err_n = 0;
  bit ovr = 0;
  ram_arbiter dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ram_err(ram_err)
  );
  always #5 CLK = ~CLK;
  // RAM model: err_n ERROR cycles, then lat BUSY cycles, then ACCESS
  always @(posedge CLK or negedge nRST)
    if (!nRST) cnt <= 0;
    else cnt <= (ramREN | ramWEN) ? cnt + 1 : 0;
  always_comb begin
    ramstate = FREE;
    if (ramREN | ramWEN) begin
      if (cnt < err_n) ramstate = ERROR;
      else if (cnt < err_n + lat) ramstate = BUSY;
      else ramstate = ACCESS;
    end
    ramload = ovr ? 32'h1234_5678 : ramaddr ^ K;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic push(input logic side, input word_t addr, input logic wr, input word_t data);
    exp_t e;
    e.side = side; e.addr = addr; e.wr = wr; e.data = data;
    sb.push_back(e);
  endtask
  task automatic wait_done(input logic side);
    int n = 0;
    while ((side ? iwait : dwait) && n < 20) begin
      tick();
      n++;
    end
    chk(side ? "i_timeout" : "d_timeout", {31'b0, side ? iwait : dwait}, 0);
  endtask
  always @(negedge CLK) begin
    exp_t e;
    if (nRST && (!iwait || !dwait)) begin
      chk("wait_excl", {31'b0, iwait | dwait}, 1);
      if (sb.size() == 0) begin
        total++;
        $display("FAIL sb_underflow: got unexpected completion i=%b d=%b expected none", !iwait, !dwait);
      end else begin
        e = sb.pop_front();
        chk("side", {31'b0, !iwait}, {31'b0, e.side});
        chk("addr", ramaddr, e.addr);
        if (!iwait) chk("iload", iload, e.data);
        else if (e.wr) chk("wr_en_store", {ramWEN, ramREN} == 2'b10 ? ramstore : 32'hFFFF_FFFF, e.data);
        else chk("dload", {ramREN, ramWEN} == 2'b10 ? dload : 32'hFFFF_FFFF, e.data);
      end
    end
  end
  initial begin
    #2;
    chk("rst_ren", {30'b0, ramREN, ramWEN}, 0);
    chk("rst_addr", ramaddr | ramstore, 0);
    chk("rst_waits", {29'b0, iwait, dwait, ram_err}, 3'b110);
    chk("rst_dload", dload, K);
    #10 nRST = 1;
    tick();
    // write priority
    dREN = 1; dWEN = 1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
    push(0, 32'h100, 1, 32'hDEAD_BEEF);
    tick();
    chk("wp_en", {30'b0, ramWEN, ramREN}, 2'b10);
    chk("wp_store", ramstore, 32'hDEAD_BEEF);
    wait_done(0);
    tick();
    dREN = 0; dWEN = 0;
    // error retry
    ovr = 1; err_n = 2; lat = 0; dREN = 1; daddr = 32'h200;
    push(0, 32'h200, 0, 32'h1234_5678);
    tick();
    chk("err_c0", {30'b0, ram_err, dwait}, 2'b11);
    tick();
    chk("err_c1", {30'b0, ram_err, dwait}, 2'b11);
    tick();
    chk("err_c2", {30'b0, ram_err, dwait}, 2'b00);
    tick();
    dREN = 0; ovr = 0; err_n = 0;
    chk("err_idle", {31'b0, ram_err}, 0);
    // contention
    lat = 2; iREN = 1; iaddr = 32'h500; dREN = 1; daddr = 32'h40;
    push(0, 32'h40, 0, 32'h40 ^ K);
    push(1, 32'h500, 0, 32'h500 ^ K);
    tick();
    chk("cont_a1", ramaddr, 32'h40);
    chk("cont_iw1", {31'b0, iwait}, 1);
    tick();
    chk("cont_a2", ramaddr, 32'h40);
    chk("cont_dw2", {30'b0, iwait, dwait}, 2'b11);
    wait_done(0);
    chk("cont_iw3", {31'b0, iwait}, 1);
    tick();
    dREN = 0;
    tick();
    chk("cont_ig", {30'b0, dut.r_state}, IGRANT);
    chk("cont_ia", ramaddr, 32'h500);
    wait_done(1);
    tick();
    iREN = 0;
    chk("cont_streak", {29'b0, dut.r_streak}, 0);
    // reset mid-grant
    lat = 5; dREN = 1; daddr = 32'h80;
    tick();
    chk("rmg_ren", {31'b0, ramREN}, 1);
    nRST = 0;
    #1;
    chk("rmg_en", {30'b0, ramREN, ramWEN}, 0);
    chk("rmg_waits", {30'b0, iwait, dwait}, 2'b11);
    chk("rmg_state", {30'b0, dut.r_state}, IDLE);
    chk("rmg_streak", {29'b0, dut.r_streak}, 0);
    dREN = 0;
    @(negedge CLK);
    nRST = 1;
    tick();
    // anti-starvation: D,D,D,D,I,D,D
    lat = 1; iREN = 1; iaddr = 32'h1000; dREN = 1; daddr = 32'h2000;
    for (int n = 0; n < 4; n++) push(0, 32'h2000 + 32'(4 * n), 0, (32'h2000 + 32'(4 * n)) ^ K);
    push(1, 32'h1000, 0, 32'h1000 ^ K);
    for (int n = 4; n < 6; n++) push(0, 32'h2000 + 32'(4 * n), 0, (32'h2000 + 32'(4 * n)) ^ K);
    for (int n = 0; n < 6; n++) begin
      wait_done(0);
      tick();
      daddr = 32'h2000 + 32'(4 * (n + 1));
      if (n == 3) chk("as_sat", {29'b0, dut.r_streak}, 4);
    end
    iREN = 0; dREN = 0;
    chk("as_streak", {29'b0, dut.r_streak}, 2);
    // abort keeps streak
    lat = 5; iREN = 1; iaddr = 32'h600;
    tick();
    chk("ab_ren", {31'b0, ramREN}, 1);
    iREN = 0;
    tick();
    chk("ab_idle", {30'b0, dut.r_state}, IDLE);
    chk("ab_ren0", {31'b0, ramREN}, 0);
    chk("ab_streak", {29'b0, dut.r_streak}, 2);
    repeat (3) tick();
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
